// File: rtl/lfsr_seq_checker.sv
// Self-seeding LFSR sequence checker: locks onto the generator's state word
// and counts sequence errors while locked.
module lfsr_seq_checker #(
  parameter int N          = 3,
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 3,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N-1:0]     data_in,
  input  logic             data_valid,
  input  logic             clr_err,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    SEARCH,
    VERIFY,
    LOCKED
  } state_t;

  localparam logic [3:0] LOCK_C   = 4'(LOCK_CNT);
  localparam logic [3:0] UNLOCK_C = 4'(UNLOCK_CNT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic [N-1:0]     pred_q, pred_d;
  logic [3:0]       match_q, match_d;
  logic [3:0]       miss_q, miss_d;
  logic             err_d;
  logic [CNT_W-1:0] cnt_base, cnt_d;
  logic             is_zero, hit;

  function automatic logic [N-1:0] nxt(input logic [N-1:0] s);
    return {s[0] ^ s[1], s[N-1:1]};
  endfunction

  assign is_zero = (data_in == '0);
  assign hit     = (data_in == pred_q);

  always_comb begin
    state_d = state_q;
    pred_d  = pred_q;
    match_d = match_q;
    miss_d  = miss_q;
    err_d   = 1'b0;
    if (data_valid) begin
      unique case (1'b1)
        state_q == SEARCH: begin
          if (!is_zero) begin
            pred_d  = nxt(data_in);
            match_d = '0;
            state_d = VERIFY;
          end
        end
        state_q == VERIFY: begin
          if (hit) begin
            pred_d  = nxt(pred_q);
            match_d = match_q + 4'd1;
            if (match_q + 4'd1 == LOCK_C) begin
              state_d = LOCKED;
              miss_d  = '0;
            end
          end else if (!is_zero) begin
            pred_d  = nxt(data_in);
            match_d = '0;
          end else begin
            state_d = SEARCH;
          end
        end
        state_q == LOCKED: begin
          // Free-running prediction: a corrupt word never reseeds us.
          pred_d = nxt(pred_q);
          if (hit) begin
            miss_d = '0;
          end else begin
            err_d  = 1'b1;
            miss_d = miss_q + 4'd1;
            if (miss_q + 4'd1 == UNLOCK_C) state_d = SEARCH;
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  // Clear first, then count, so clear plus error in one cycle yields 1.
  always_comb begin
    cnt_base = clr_err ? '0 : err_cnt;
    cnt_d    = cnt_base;
    if (err_d && cnt_base != CNT_MAX) cnt_d = cnt_base + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= SEARCH;
      pred_q    <= N'(1);
      match_q   <= '0;
      miss_q    <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_cnt   <= '0;
    end else begin
      state_q   <= state_d;
      pred_q    <= pred_d;
      match_q   <= match_d;
      miss_q    <= miss_d;
      locked    <= (state_d == LOCKED);
      err_pulse <= err_d;
      err_cnt   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Directed bench for lfsr_seq_checker (N=3, LOCK_CNT=4, UNLOCK_CNT=3,
// CNT_W=8) with immediate-assertion checks.
module tb_lfsr_seq_checker;

  logic       clk;
  logic       reset_n;
  logic [2:0] data_in;
  logic       data_valid;
  logic       clr_err;
  logic       locked;
  logic       err_pulse;
  logic [7:0] err_cnt;

  int checks   = 0;
  int failures = 0;

  lfsr_seq_checker #(
    .N(3),
    .LOCK_CNT(4),
    .UNLOCK_CNT(3),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .data_in(data_in),
    .data_valid(data_valid),
    .clr_err(clr_err),
    .locked(locked),
    .err_pulse(err_pulse),
    .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] gen(input logic [2:0] s);
    return {s[0] ^ s[1], s[2:1]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic v, input logic [2:0] d);
    data_valid = v;
    data_in    = d;
    @(posedge clk);
    #1;
    data_valid = 1'b0;
  endtask

  logic [2:0] e;

  initial begin
    reset_n    = 1'b0;
    data_in    = 3'b000;
    data_valid = 1'b0;
    clr_err    = 1'b0;
    #12;
    chk("rst_locked", 32'(locked), 0);
    chk("rst_pulse", 32'(err_pulse), 0);
    chk("rst_cnt", 32'(err_cnt), 0);
    reset_n = 1'b1;

    // Lock on the reference order
    send(1, 3'b001);
    send(1, 3'b100);
    send(1, 3'b010);
    send(1, 3'b101);
    chk("t1_not_yet", 32'(locked), 0);
    send(1, 3'b110);
    chk("t1_locked", 32'(locked), 1);
    chk("t1_cnt", 32'(err_cnt), 0);
    chk("t1_pulse", 32'(err_pulse), 0);

    // Single corrupt word in place of 111
    send(1, 3'b000);
    chk("t2_pulse", 32'(err_pulse), 1);
    chk("t2_cnt", 32'(err_cnt), 1);
    chk("t2_locked", 32'(locked), 1);
    send(1, 3'b011);
    chk("t2_pulse_one", 32'(err_pulse), 0);
    chk("t2_cnt_hold", 32'(err_cnt), 1);
    send(1, 3'b001);
    chk("t2_match", 32'(err_pulse), 0);
    chk("t2_locked2", 32'(locked), 1);
    send(0, 3'b111);
    chk("gap_pulse", 32'(err_pulse), 0);
    chk("gap_cnt", 32'(err_cnt), 1);

    // clr_err alone
    clr_err = 1'b1;
    send(0, 3'b000);
    clr_err = 1'b0;
    chk("clr_cnt", 32'(err_cnt), 0);
    chk("clr_locked", 32'(locked), 1);

    // Three misses in a row drop lock
    send(1, 3'b000);
    send(1, 3'b000);
    chk("t3_still", 32'(locked), 1);
    chk("t3_cnt2", 32'(err_cnt), 2);
    send(1, 3'b000);
    chk("t3_cnt", 32'(err_cnt), 3);
    chk("t3_unlock", 32'(locked), 0);
    chk("t3_pulse", 32'(err_pulse), 1);
    send(1, 3'b001);
    send(1, 3'b100);
    send(1, 3'b010);
    send(1, 3'b101);
    send(1, 3'b110);
    chk("t3_relock", 32'(locked), 1);
    chk("t3_cnt_kept", 32'(err_cnt), 3);

    // Alternate bad/good words until the counter saturates
    e = 3'b111;
    for (int i = 0; i < 300; i++) begin
      send(1, e ^ 3'b111);
      e = gen(e);
      if (i == 0) chk("t5_first", 32'(err_cnt), 4);
      send(1, e);
      e = gen(e);
    end
    chk("t5_sat", 32'(err_cnt), 255);
    chk("t5_locked", 32'(locked), 1);
    clr_err = 1'b1;
    send(1, e ^ 3'b111);
    clr_err = 1'b0;
    e = gen(e);
    chk("t5_clr_err", 32'(err_cnt), 1);
    chk("t5_clr_pulse", 32'(err_pulse), 1);
    chk("t5_clr_lock", 32'(locked), 1);

    // Async reset between edges
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_locked", 32'(locked), 0);
    chk("t6_cnt", 32'(err_cnt), 0);
    chk("t6_pulse", 32'(err_pulse), 0);
    #3;
    reset_n = 1'b1;

    // Zeros in SEARCH, gaps, and a reseed in VERIFY
    send(1, 3'b000);
    send(1, 3'b000);
    send(1, 3'b000);
    chk("t4_zero", 32'(locked), 0);
    send(1, 3'b001);
    send(0, 3'b111);
    send(1, 3'b100);
    send(0, 3'b000);
    send(1, 3'b011);
    chk("t4_reseed", 32'(locked), 0);
    send(1, 3'b001);
    send(0, 3'b110);
    send(1, 3'b100);
    send(0, 3'b000);
    send(1, 3'b010);
    chk("t4_not_yet", 32'(locked), 0);
    send(0, 3'b011);
    send(1, 3'b101);
    chk("t4_locked", 32'(locked), 1);
    chk("t4_cnt", 32'(err_cnt), 0);
    chk("t4_pulse", 32'(err_pulse), 0);
    send(1, 3'b110);
    chk("t4_track", 32'(err_pulse), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
